// File: rtl/counter_cycle_arbiter.sv
// Counter-increment cycle arbiter: latches per-counter PINC/MINC requests, parks the
// sequencer and performs a ones'-complement read-modify-write on the counter word.
module counter_cycle_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  pinc_req,
    input  logic [7:0]  minc_req,
    input  logic        seq_park,
    output logic        seq_go,
    output logic        own_bus,
    output logic [11:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_wdata,
    output logic        mem_wr,
    output logic [7:0]  ovf,
    output logic        drop
);

    localparam int unsigned NCTR  = 8;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned AW    = 12;
    localparam int unsigned DW    = 16;
    localparam int unsigned XW    = 15;
    localparam logic [AW-1:0] CTR_BASE = 12'h014;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_READ,
        S_MODIFY,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t            state_q;
    logic [NCTR-1:0]   up_q, up_d;
    logic [NCTR-1:0]   dn_q, dn_d;
    logic [IDX_W-1:0]  last_q;
    logic [IDX_W-1:0]  idx_q;
    logic              dir_q;
    logic              own_bus_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DW-1:0]     mem_wdata_q;
    logic              mem_wr_q;
    logic [NCTR-1:0]   ovf_q;
    logic              drop_q;

    logic              any_pend;
    logic [IDX_W-1:0]  sel_idx;
    logic [IDX_W-1:0]  cand;
    logic              sel_found;
    logic              sel_dir;
    logic [NCTR-1:0]   up_base, dn_base;
    logic              drop_c;
    logic [XW-1:0]     x;
    logic [XW-1:0]     res;
    logic              ovf_c;
    logic              unused_rdata_msb;

    assign any_pend         = |(up_q | dn_q);
    assign unused_rdata_msb = mem_rdata[15];

    // Round-robin search starting just after the last serviced counter.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= int'(NCTR); k++) begin
            cand = last_q + IDX_W'(k);
            if (!sel_found && (up_q[cand] || dn_q[cand])) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
        sel_dir = up_q[sel_idx];
    end

    // Pending update: the serviced bit is cleared first so a same-cycle request re-sets it.
    always_comb begin
        up_base = up_q;
        dn_base = dn_q;
        if (state_q == S_SELECT && sel_found) begin
            if (sel_dir) up_base[sel_idx] = 1'b0;
            else         dn_base[sel_idx] = 1'b0;
        end
        up_d   = up_base;
        dn_d   = dn_base;
        drop_c = 1'b0;
        for (int i = 0; i < int'(NCTR); i++) begin
            if (pinc_req[i] && !minc_req[i]) begin
                if (dn_base[i])      dn_d[i] = 1'b0;
                else if (up_base[i]) drop_c  = 1'b1;
                else                 up_d[i] = 1'b1;
            end else if (minc_req[i] && !pinc_req[i]) begin
                if (up_base[i])      up_d[i] = 1'b0;
                else if (dn_base[i]) drop_c  = 1'b1;
                else                 dn_d[i] = 1'b1;
            end
        end
    end

    // 15-bit ones'-complement increment/decrement with the -0 and max cases.
    always_comb begin
        x     = mem_rdata[XW-1:0];
        res   = '0;
        ovf_c = 1'b0;
        if (dir_q) begin
            if (x == 15'h7FFF)      res = 15'h0001;
            else if (x == 15'h3FFF) begin
                res   = 15'h0000;
                ovf_c = 1'b1;
            end else                res = x + 15'd1;
        end else begin
            if (x == 15'h0000)      res = 15'h7FFE;
            else if (x == 15'h4000) begin
                res   = 15'h7FFF;
                ovf_c = 1'b1;
            end else                res = x - 15'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            up_q        <= '0;
            dn_q        <= '0;
            last_q      <= IDX_W'(NCTR - 1);
            idx_q       <= '0;
            dir_q       <= 1'b0;
            own_bus_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            ovf_q       <= '0;
            drop_q      <= 1'b0;
        end else begin
            up_q     <= up_d;
            dn_q     <= dn_d;
            drop_q   <= drop_c;
            mem_wr_q <= 1'b0;
            ovf_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (any_pend && seq_park) state_q <= S_SELECT;
                end
                S_SELECT: begin
                    // Pending may have been cancelled on the entry edge; fall back to idle.
                    if (sel_found) begin
                        idx_q      <= sel_idx;
                        dir_q      <= sel_dir;
                        last_q     <= sel_idx;
                        mem_addr_q <= CTR_BASE + AW'(sel_idx);
                        own_bus_q  <= 1'b1;
                        state_q    <= S_READ;
                    end else begin
                        state_q    <= S_IDLE;
                    end
                end
                S_READ: begin
                    state_q <= S_MODIFY;
                end
                S_MODIFY: begin
                    mem_wdata_q <= {res[XW-1], res};
                    mem_wr_q    <= 1'b1;
                    ovf_q       <= NCTR'(ovf_c) << idx_q;
                    state_q     <= S_WRITE;
                end
                S_WRITE: begin
                    own_bus_q <= 1'b0;
                    state_q   <= S_RELEASE;
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign seq_go    = (state_q == S_IDLE) && !any_pend;
    assign own_bus   = own_bus_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wr    = mem_wr_q;
    assign ovf       = ovf_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_counter_cycle_arbiter.sv
// Bench for counter_cycle_arbiter: directed requests, expected writes queued in a
// scoreboard and compared by a monitor whenever mem_wr is seen.
module tb_counter_cycle_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pinc_req;
    logic [7:0]  minc_req;
    logic        seq_park;
    logic        seq_go;
    logic        own_bus;
    logic [11:0] mem_addr;
    logic [15:0] mem_rdata;
    logic [15:0] mem_wdata;
    logic        mem_wr;
    logic [7:0]  ovf;
    logic        drop;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [11:0] addr;
        logic [15:0] data;
        logic [7:0]  ovf;
    } exp_t;

    exp_t exp_q[$];
    logic [15:0] mem [0:4095];

    always #5 clk = ~clk;

    counter_cycle_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pinc_req  (pinc_req),
        .minc_req  (minc_req),
        .seq_park  (seq_park),
        .seq_go    (seq_go),
        .own_bus   (own_bus),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_wr    (mem_wr),
        .ovf       (ovf),
        .drop      (drop)
    );

    // Synchronous memory: one-cycle read latency, write on strobe.
    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] = mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic push(input logic [11:0] a, input logic [15:0] d, input logic [7:0] o);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.ovf  = o;
        exp_q.push_back(e);
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
                chk("wr_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] p, input logic [7:0] m);
        pinc_req = p;
        minc_req = m;
        tick();
        pinc_req = '0;
        minc_req = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(seq_go && !own_bus) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(seq_go && !own_bus), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_seq_go"},  32'(seq_go),    32'd1);
        chk({tag, "_own_bus"}, 32'(own_bus),   32'd0);
        chk({tag, "_addr"},    32'(mem_addr),  32'd0);
        chk({tag, "_wdata"},   32'(mem_wdata), 32'd0);
        chk({tag, "_wr"},      32'(mem_wr),    32'd0);
        chk({tag, "_ovf"},     32'(ovf),       32'd0);
        chk({tag, "_drop"},    32'(drop),      32'd0);
    endtask

    task automatic count_own_bus(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (own_bus) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cnt;
        rst_n    = 1'b0;
        pinc_req = '0;
        minc_req = '0;
        seq_park = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        #23;
        check_reset("rst_hold");
        rst_n = 1'b1;
        tick();
        check_reset("rst_rel");

        // Basic PINC with latency checks.
        seq_park = 1'b1;
        mem[12'h014] = 16'h0005;
        push(12'h014, 16'h0006, 8'h00);
        pulse(8'h01, 8'h00);
        chk("t1_seq_go_drop", 32'(seq_go), 32'd0);
        k = 0;
        while (k < 10 && !mem_wr) begin
            tick();
            k++;
        end
        chk("t1_wr_latency", 32'(k), 32'd4);
        tick();
        chk("t1_release_own_bus", 32'(own_bus), 32'd0);
        chk("t1_release_seq_go", 32'(seq_go), 32'd0);
        tick();
        chk("t1_seq_go_back", 32'(seq_go), 32'd1);

        // Overflow and ones'-complement corner values on counter 1.
        mem[12'h015] = 16'h3FFF;
        push(12'h015, 16'h0000, 8'h02);
        pulse(8'h02, 8'h00);
        wait_idle(50);
        mem[12'h015] = 16'h4000;
        push(12'h015, 16'hFFFF, 8'h02);
        pulse(8'h00, 8'h02);
        wait_idle(50);
        mem[12'h015] = 16'h0000;
        push(12'h015, 16'hFFFE, 8'h00);
        pulse(8'h00, 8'h02);
        wait_idle(50);
        mem[12'h015] = 16'h7FFF;
        push(12'h015, 16'h0001, 8'h00);
        pulse(8'h02, 8'h00);
        wait_idle(50);

        // Cancellation: same-cycle opposite requests, then opposite requests in sequence.
        pulse(8'h04, 8'h04);
        chk("t3_same_cycle_seq_go", 32'(seq_go), 32'd1);
        count_own_bus(6, cnt);
        chk("t3_same_cycle_no_bus", 32'(cnt), 32'd0);
        seq_park = 1'b0;
        pulse(8'h08, 8'h00);
        chk("t3_pend_seq_go", 32'(seq_go), 32'd0);
        pulse(8'h00, 8'h08);
        chk("t3_cancel_seq_go", 32'(seq_go), 32'd1);
        seq_park = 1'b1;
        count_own_bus(6, cnt);
        chk("t3_cancel_no_bus", 32'(cnt), 32'd0);

        // Round robin from a fresh reset: counters 0..7 in order.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            mem[12'h014 + 12'(i)] = 16'h0100 + 16'(i);
            push(12'h014 + 12'(i), 16'h0101 + 16'(i), 8'h00);
        end
        pulse(8'hFF, 8'h00);
        wait_idle(100);
        chk("t4_rr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Make last=3, then counters 0 and 5 pending: 5 goes first.
        push(12'h017, 16'h0105, 8'h00);
        pulse(8'h08, 8'h00);
        wait_idle(50);
        seq_park = 1'b0;
        push(12'h019, 16'h0107, 8'h00);
        push(12'h014, 16'h0102, 8'h00);
        pulse(8'h21, 8'h00);
        seq_park = 1'b1;
        wait_idle(50);

        // Hold with seq_park low, duplicate request drops once, then one write.
        seq_park = 1'b0;
        mem[12'h018] = 16'h1234;
        pulse(8'h10, 8'h00);
        chk("t5_hold_own_bus", 32'(own_bus), 32'd0);
        chk("t5_hold_seq_go", 32'(seq_go), 32'd0);
        chk("t5_first_no_drop", 32'(drop), 32'd0);
        pulse(8'h10, 8'h00);
        chk("t5_drop_pulse", 32'(drop), 32'd1);
        tick();
        chk("t5_drop_clear", 32'(drop), 32'd0);
        chk("t5_still_no_bus", 32'(own_bus), 32'd0);
        push(12'h018, 16'h1235, 8'h00);
        seq_park = 1'b1;
        wait_idle(50);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Async reset during WRITE: counter 6 in flight, counter 2 still pending.
        mem[12'h01A] = 16'h0050;
        pulse(8'h44, 8'h00);
        k = 0;
        while (k < 10 && !mem_wr) begin
            tick();
            k++;
        end
        chk("t6_write_seen", 32'(mem_wr), 32'd1);
        chk("t6_write_addr", 32'(mem_addr), 32'h01A);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_wr_fall", 32'(mem_wr), 32'd0);
        chk("t6_bus_fall", 32'(own_bus), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_reset("t6_after");
        count_own_bus(8, cnt);
        chk("t6_pending_discarded", 32'(cnt), 32'd0);
        chk("t6_seq_go_idle", 32'(seq_go), 32'd1);
        chk("t6_mem_untouched", 32'(mem[12'h01A]), 32'h0050);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_cycle_arbiter.md
# counter_cycle_arbiter

Schedules AGC-style counter-increment (PINC/MINC) cycles on the shared memory port between instructions. Eight counter cells raise increment/decrement requests asynchronously to instruction execution. The arbiter latches them, parks the instruction sequencer at its instruction boundary, and performs a read–modify–write on the counter word in ones'-complement. It then releases the memory port back to the sequencer.

## Interface
- CTR_BASE, 12'h014, memory address of counter 0; counter i lives at CTR_BASE+i
- NCTR, 8, number of counter cells (fixed at 8; index width 3)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pinc_req  in  8  per-counter increment request, sampled every cycle (one-cycle pulse = one request)
- minc_req  in  8  per-counter decrement request, sampled every cycle
- seq_park  in  1  high while the sequencer sits at the instruction boundary, not driving memory
- seq_go  out  1  combinational: state==IDLE and no request pending; the sequencer leaves the boundary only when seq_park&&seq_go
- own_bus  out  1  arbiter drives mem_addr/mem_wdata/mem_wr; steers the memory muxes
- mem_addr  out  12  counter address, valid while own_bus
- mem_rdata  in  16  synchronous read data, valid one cycle after the address
- mem_wdata  out  16  write data
- mem_wr  out  1  one-cycle write strobe
- ovf  out  8  one-cycle overflow pulse for the counter written
- drop  out  1  one-cycle pulse: a request was lost to an identical pending request

## Operation
- Pending state: 2 bits per counter (up, dn), never both set.
  - pinc_req[i] sets up[i]; minc_req[i] sets dn[i].
  - Opposite requests cancel. Both bits asserted in the same cycle leave the state unchanged. A request opposite an existing pending bit clears that bit.
  - A request arriving while the same-direction bit is already set is lost and pulses drop.
- FSM states: IDLE, SELECT, READ, MODIFY, WRITE, RELEASE.
  - IDLE: when any bit is pending and seq_park=1, go to SELECT.
  - SELECT: round-robin pick starting at last+1 mod 8. Latch idx and dir. Clear that counter's pending bit; a same-cycle new request for that counter re-sets it. Update last=idx. Go to READ.
  - READ: own_bus=1, mem_addr=CTR_BASE+idx. Go to MODIFY.
  - MODIFY: capture x=mem_rdata[14:0] and compute the result into a register. own_bus held. Go to WRITE.
  - WRITE: mem_wr=1, mem_wdata={r[14],r[14:0]}. Pulse ovf[idx] if overflow. Go to RELEASE.
  - RELEASE: own_bus=0. Go to IDLE.
- PINC arithmetic, 15-bit ones'-complement:
  - x=7FFF (−0) → 0001.
  - x=3FFF (+max) → 0000 with overflow.
  - All other x → x+1. Example: 7FFE → 7FFF.
- MINC arithmetic:
  - x=0000 → 7FFE.
  - x=4000 (−max) → 7FFF with overflow.
  - All other x → x−1.
- mem_rdata[15] is ignored.

## Timing
- Reset values: seq_go=1 (IDLE, nothing pending), own_bus=0, mem_addr=0, mem_wdata=0, mem_wr=0, ovf=0, drop=0, pending=0, last=7 (so counter 0 wins first).
- Reset mid-cycle takes effect immediately (asynchronous): any in-flight write is aborted, mem_wr and own_bus drop at once, and pending requests are discarded.
- Latency: a request sampled on edge N is pending after N. With seq_park high, SELECT starts at N+1 and own_bus rises at N+2 (READ). mem_wr fires at N+4 and RELEASE is at N+5. seq_go reasserts at N+6 if nothing else is pending.
- One counter cycle occupies 5 clocks. Back-to-back cycles go RELEASE→IDLE→SELECT, with no sequencer progress in between while anything is pending.
- seq_park low in IDLE: no cycle starts, and requests keep accumulating.
- seq_park is not re-checked after SELECT: the sequencer is required to stay parked while seq_go=0.
- seq_go is combinational from registers only; it has no path from inputs.

## Test plan
- Reset, then pinc_req[0] pulse with seq_park=1 and mem[0x014]=0005:
  - seq_go drops.
  - mem_wr is seen exactly 4 cycles after the request edge, with addr 0x014 and data 0006.
  - seq_go returns 2 cycles later.
  - ovf=0.
- Overflow:
  - PINC with mem[0x015]=3FFF → writes 0000 and pulses ovf[1].
  - MINC with 4000 → writes 7FFF and pulses ovf[1].
  - MINC with 0000 → writes 7FFE.
  - PINC with 7FFF → writes 0001.
- Cancellation: pinc_req[2] and minc_req[2] in the same cycle → no memory cycle, seq_go stays 1. pinc_req[3] then minc_req[3] one cycle later with seq_park=0 → pending is empty and no cycle occurs.
- Round-robin fairness: all 8 pinc_req pulsed together, seq_park=1 → eight 5-cycle write cycles at addresses 0x014..0x01B in order. Then pinc[0] and pinc[5] pending with last=3 → counter 5 is serviced first.
- Hold and drop: requests with seq_park=0 → no own_bus and seq_go=0. A second pinc_req[4] while up[4] is pending → drop pulses once. Raising seq_park → exactly one write, of x+1.
- Async reset: rst_n low during the WRITE cycle → mem_wr and own_bus fall within the same cycle, and after release all outputs equal their reset values.
